step_pulse_gen: RTL

Downstream stage of the rate divider: converts the divider's raw step-rate pulses plus a direction bit into driver-legal STEP/DIR outputs. It enforces minimum step high/low time and DIR-to-STEP setup time, and maintains a signed absolute position count per axis. One instance per motor axis. The STEP/DIR outputs go to the driver pins and the position count goes to the host register file.

---
 rtl/qs_pkg.sv | 16 +
 rtl/edge_detector.sv | 32 +++
 rtl/step_pulse_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/qs_pkg.sv
// qs_pkg
// Shared definitions for the quad-stepper motion blocks.
//   step_state_t  : STEP/DIR sequencer states
//   QS_TIMER_BITS : width of the shared timing down-counter (covers 1..255)
package qs_pkg;

    localparam int QS_TIMER_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } step_state_t;

endpackage

// File: rtl/edge_detector.sv
// edge_detector
// Registered rising-edge detector. The input is sampled every clock. The
// output is high for one cycle after a sample of 1 that follows a sample of 0.
// Because of this, a 0->1 seen at posedge N is reported during cycle N..N+1
// and is acted on at posedge N+1.
//   clk   : clock
//   rst_n : async active-low reset
//   sig   : level input
//   rise  : one-cycle pulse, registered sample history
module edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;
    logic sig_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q  <= 1'b0;
            sig_qq <= 1'b0;
        end else begin
            sig_q  <= sig;
            sig_qq <= sig_q;
        end
    end

    assign rise = sig_q & ~sig_qq;

endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen
// Converts raw step-rate pulses plus a direction bit into STEP/DIR outputs
// that a motor driver accepts. The block enforces the STEP high time, the
// minimum STEP low time and the DIR-to-STEP setup time. It also keeps a
// signed position count for the axis.
//   clk, rst_n   : clock, async active-low reset
//   enable       : gate for new step requests
//   step_in      : step request, one request per rising edge
//   dir_in       : direction of the request (1 = positive)
//   pos_load     : one-cycle strobe that loads position from pos_load_val
//   clear_missed : clears the sticky missed flag
//   step_out     : driver STEP (registered)
//   dir_out      : driver DIR (registered)
//   position     : two's complement step count, wraps
//   busy         : sequencer active or a request pending (registered)
//   missed       : sticky flag, set when a request arrives with the slot full
module step_pulse_gen
    import qs_pkg::*;
#(
    parameter int POS_BITS    = 32,
    parameter int PULSE_WIDTH = 20,
    parameter int DIR_SETUP   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                step_in,
    input  logic                dir_in,
    input  logic                pos_load,
    input  logic [POS_BITS-1:0] pos_load_val,
    input  logic                clear_missed,
    output logic                step_out,
    output logic                dir_out,
    output logic [POS_BITS-1:0] position,
    output logic                busy,
    output logic                missed
);

    // The timer counts down to zero, so a phase of N cycles loads N-1.
    localparam logic [QS_TIMER_BITS-1:0] PW_LD = QS_TIMER_BITS'(PULSE_WIDTH - 1);
    localparam logic [QS_TIMER_BITS-1:0] DS_LD = QS_TIMER_BITS'(DIR_SETUP - 1);
    localparam logic [QS_TIMER_BITS-1:0] T_ONE = QS_TIMER_BITS'(1);

    step_state_t              state, state_nxt;
    logic [QS_TIMER_BITS-1:0] timer, timer_nxt;
    logic                     pend, pend_nxt;
    logic                     pend_dir, pend_dir_nxt;
    logic                     dir_nxt;
    logic                     dir_q;
    logic                     req_edge;
    logic                     req;
    logic                     free;
    logic                     launch;
    logic                     launch_dir;
    logic                     missed_set;
    logic                     pulse_rise;
    logic [POS_BITS-1:0]      pos_base;
    logic [POS_BITS-1:0]      pos_delta;

    edge_detector u_step_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (step_in),
        .rise  (req_edge)
    );

    // dir_in is captured on the same edge that samples step_in high. This
    // keeps the direction aligned with its request after the detector delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dir_q <= 1'b0;
        else        dir_q <= dir_in;
    end

    assign req = req_edge & enable;

    // The sequencer can take a new pulse this cycle when it is idle or in the
    // last LOW cycle. Because of this, a back-to-back request needs no idle gap.
    assign free = (state == IDLE) || (state == LOW && timer == '0);

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        pend_nxt     = pend & enable;   // dropping enable discards the slot
        pend_dir_nxt = pend_dir;
        dir_nxt      = dir_out;
        missed_set   = 1'b0;
        launch       = 1'b0;
        launch_dir   = dir_q;

        // The pending request goes first. A new edge that arrives while the
        // slot is still full counts as an overrun, even though the slot empties
        // in this same cycle.
        if (free && pend && enable) begin
            launch     = 1'b1;
            launch_dir = pend_dir;
            pend_nxt   = 1'b0;
            missed_set = req;
        end else if (req) begin
            if (free) begin
                launch = 1'b1;
            end else if (!pend) begin
                pend_nxt     = 1'b1;
                pend_dir_nxt = dir_q;
            end else begin
                missed_set = 1'b1;
            end
        end

        unique case (state)
            IDLE: begin
            end
            SETUP: begin
                if (timer == '0) begin
                    state_nxt = HIGH;
                    timer_nxt = PW_LD;
                end else begin
                    timer_nxt = timer - T_ONE;
                end
            end
            HIGH: begin
                if (timer == '0) begin
                    state_nxt = LOW;
                    timer_nxt = PW_LD;
                end else begin
                    timer_nxt = timer - T_ONE;
                end
            end
            LOW: begin
                if (timer == '0) state_nxt = IDLE;
                else             timer_nxt = timer - T_ONE;
            end
        endcase

        // A launch overrides the exit from LOW or IDLE worked out above.
        if (launch) begin
            if (launch_dir != dir_out) begin
                state_nxt = SETUP;
                timer_nxt = DS_LD;
                dir_nxt   = launch_dir;
            end else begin
                state_nxt = HIGH;
                timer_nxt = PW_LD;
            end
        end
    end

    // STEP rises exactly when the registered output goes 0->1. The position
    // uses the DIR value already on the pins, and DIR is stable by then.
    assign pulse_rise = (state_nxt == HIGH) && !step_out;
    assign pos_base   = pos_load ? pos_load_val : position;
    assign pos_delta  = !pulse_rise ? '0 : (dir_out ? POS_BITS'(1) : '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            pend     <= 1'b0;
            pend_dir <= 1'b0;
            dir_out  <= 1'b0;
            step_out <= 1'b0;
            busy     <= 1'b0;
            missed   <= 1'b0;
            position <= '0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            pend     <= pend_nxt;
            pend_dir <= pend_dir_nxt;
            dir_out  <= dir_nxt;
            step_out <= (state_nxt == HIGH);
            busy     <= (state_nxt != IDLE) || pend_nxt;
            missed   <= missed_set | (missed & ~clear_missed);
            position <= pos_base + pos_delta;
        end
    end

endmodule
